pwm_cfg_loader: RTL

PWM_CFG_LOADER -- requirements
Module: pwm_cfg_loader

---
 rtl/pwm_cfg_loader_pkg.sv | 16 +
 rtl/pwm_cfg_loader_sync_edge_det.sv | 30 +++
 rtl/pwm_cfg_loader.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/pwm_cfg_loader_pkg.sv
// Shared types and frame layout for the serial PWM configuration loader.
package pwm_cfg_loader_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        CHECK,
        WAIT_HIGH
    } state_t;

    localparam int unsigned SEL_BIT          = 15;
    localparam int unsigned DATA_MSB         = 11;
    localparam int unsigned DATA_W           = DATA_MSB + 1;
    localparam int unsigned DUTY_MAX_DEFAULT = 100;

endpackage

// File: rtl/pwm_cfg_loader_sync_edge_det.sv
// Multi-flop synchronizer for one asynchronous input plus a change detector
// on the synchronized level; the consumer decodes rise/fall from level+toggle.
module sync_edge_det #(
    parameter int unsigned STAGES  = 2,
    parameter logic        RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic i_async,
    output logic o_sync,
    output logic o_toggle_c
);

    logic [STAGES-1:0] r_chain;
    logic              r_prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_chain <= {STAGES{RST_VAL}};
            r_prev  <= RST_VAL;
        end else begin
            r_chain <= (r_chain << 1) | STAGES'(i_async);
            r_prev  <= r_chain[STAGES-1];
        end
    end

    assign o_sync     = r_chain[STAGES-1];
    assign o_toggle_c = r_chain[STAGES-1] ^ r_prev;

endmodule

// File: rtl/pwm_cfg_loader.sv
// Receives serial configuration frames (sel + 12-bit data) and converts each
// valid frame into a single write strobe toward a PWM generator.
module pwm_cfg_loader
    import pwm_cfg_loader_pkg::*;
#(
    parameter int unsigned FRAME_BITS  = 16,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned DUTY_MAX    = DUTY_MAX_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sclk,
    input  logic              cs_n,
    input  logic              mosi,
    output logic [DATA_W-1:0] cfg_data,
    output logic              cfg_sel,
    output logic              cfg_wr_en,
    output logic              busy,
    output logic              frame_err,
    output logic              duty_clamped
);

    localparam int unsigned CNT_W    = $clog2(FRAME_BITS + 2);
    localparam int unsigned SETTLE_W = $clog2(SYNC_STAGES + 1);
    localparam logic [CNT_W-1:0]    CNT_FULL   = CNT_W'(FRAME_BITS);
    localparam logic [CNT_W-1:0]    CNT_SAT    = CNT_W'(FRAME_BITS + 1);
    localparam logic [SETTLE_W-1:0] SETTLE_END = SETTLE_W'(SYNC_STAGES);
    localparam logic [DATA_W-1:0]   DUTY_LIM   = DATA_W'(DUTY_MAX);

    state_t               r_state;
    logic [CNT_W-1:0]     r_cnt;
    logic [SETTLE_W-1:0]  r_settle;
    logic [FRAME_BITS-1:0] r_shift;
    logic [SYNC_STAGES-1:0] r_mosi_chain;
    logic [DATA_W-1:0]    r_cfg_data;
    logic                 r_cfg_sel;
    logic                 r_wr_en;
    logic                 r_busy;
    logic                 r_err;
    logic                 r_clamped;

    logic w_sclk_sync, w_sclk_tgl, w_cs_sync, w_cs_tgl;
    logic w_sclk_rise, w_cs_rise, w_cs_fall, w_mosi, w_sel;
    logic [DATA_W-1:0] w_data;

    sync_edge_det #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk_sync (
        .clk        (clk),
        .rst        (rst),
        .i_async    (sclk),
        .o_sync     (w_sclk_sync),
        .o_toggle_c (w_sclk_tgl)
    );

    sync_edge_det #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs_sync (
        .clk        (clk),
        .rst        (rst),
        .i_async    (cs_n),
        .o_sync     (w_cs_sync),
        .o_toggle_c (w_cs_tgl)
    );

    // mosi travels the same depth as sclk so it is aligned with the sclk rise
    always_ff @(posedge clk) begin
        if (rst) r_mosi_chain <= '0;
        else     r_mosi_chain <= (r_mosi_chain << 1) | SYNC_STAGES'(mosi);
    end

    assign w_mosi      = r_mosi_chain[SYNC_STAGES-1];
    assign w_sclk_rise = w_sclk_tgl & w_sclk_sync;
    assign w_cs_rise   = w_cs_tgl & w_cs_sync;
    assign w_cs_fall   = w_cs_tgl & ~w_cs_sync;
    assign w_sel       = r_shift[SEL_BIT];
    assign w_data      = r_shift[DATA_MSB:0];

    // WAIT_HIGH first lets the synchronizers flush their reset values, then
    // waits for a real cs_n high so a frame cut by reset is dropped silently.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= WAIT_HIGH;
            r_settle   <= '0;
            r_cnt      <= '0;
            r_shift    <= '0;
            r_cfg_data <= '0;
            r_cfg_sel  <= 1'b0;
            r_wr_en    <= 1'b0;
            r_busy     <= 1'b0;
            r_err      <= 1'b0;
            r_clamped  <= 1'b0;
        end else begin
            r_wr_en   <= 1'b0;
            r_err     <= 1'b0;
            r_clamped <= 1'b0;
            case (r_state)
                WAIT_HIGH: begin
                    if (r_settle != SETTLE_END) r_settle <= r_settle + 1'b1;
                    else if (w_cs_sync)         r_state  <= IDLE;
                end
                IDLE: begin
                    if (w_cs_fall) begin
                        r_state <= SHIFT;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (w_cs_rise) begin
                        r_state <= CHECK;
                    end else if (w_sclk_rise) begin
                        r_shift <= {r_shift[FRAME_BITS-2:0], w_mosi};
                        if (r_cnt != CNT_SAT) r_cnt <= r_cnt + 1'b1;
                    end
                end
                CHECK: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    if (r_cnt == CNT_FULL) begin
                        r_wr_en   <= 1'b1;
                        r_cfg_sel <= w_sel;
                        if (!w_sel && (w_data > DUTY_LIM)) begin
                            r_cfg_data <= DUTY_LIM;
                            r_clamped  <= 1'b1;
                        end else begin
                            r_cfg_data <= w_data;
                        end
                    end else begin
                        r_err <= 1'b1;
                    end
                end
                default: r_state <= WAIT_HIGH;
            endcase
        end
    end

    assign cfg_data     = r_cfg_data;
    assign cfg_sel      = r_cfg_sel;
    assign cfg_wr_en    = r_wr_en;
    assign busy         = r_busy;
    assign frame_err    = r_err;
    assign duty_clamped = r_clamped;

endmodule
